// File: rtl/lsu_pkg.sv
// LSU shared types: FSM states, access size, fault cause, AXI response.
// Also the byte-offset width helper used by the top and the aligner.
package lsu_pkg;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_RD_ADDR = 6'b000010,
    S_RD_DATA = 6'b000100,
    S_WR_REQ  = 6'b001000,
    S_WR_RESP = 6'b010000,
    S_DONE    = 6'b100000
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    C_NONE     = 2'd0,
    C_MISALIGN = 2'd1,
    C_BUS      = 2'd2,
    C_ILLEGAL  = 2'd3
  } lsu_cause_e;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_OKAY = 2'b00;

  function automatic int off_w(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: misalign check, store strobe/shift, load
// extract with sign/zero extension. Ports: size, low addr bits, data in/out.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AXI_DW = 32,
  parameter int OW     = off_w(AXI_DW),
  parameter int LW     = (OW > 3) ? OW : 3
) (
  input  lsu_size_e           size_i,
  input  logic [LW-1:0]       addr_lo_i,
  input  logic                sgn_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [AXI_DW-1:0]   rdata_i,
  output logic                misalign_o,
  output logic [AXI_DW/8-1:0] strb_o,
  output logic [AXI_DW-1:0]   wdata_o,
  output logic [XLEN-1:0]     ldata_o
);

  localparam int SW = AXI_DW / 8;

  logic [OW-1:0]   off;
  logic [OW+2:0]   shamt;
  logic [SW-1:0]   bmask;
  logic [XLEN-1:0] val;
  logic [XLEN-1:0] mask;
  logic            sbit;

  assign off   = addr_lo_i[OW-1:0];
  assign shamt = {off, 3'b000};
  assign val   = XLEN'(rdata_i >> shamt);

  always_comb begin
    misalign_o = 1'b0;
    bmask      = '0;
    mask       = '1;
    sbit       = 1'b0;
    unique case (size_i)
      SZ_B: begin
        bmask = SW'(8'h01);
        mask  = XLEN'(64'hFF);
        sbit  = val[7];
      end
      SZ_H: begin
        misalign_o = addr_lo_i[0];
        bmask      = SW'(8'h03);
        mask       = XLEN'(64'hFFFF);
        sbit       = val[15];
      end
      SZ_W: begin
        misalign_o = |addr_lo_i[1:0];
        bmask      = SW'(8'h0F);
        mask       = XLEN'(64'hFFFF_FFFF);
        sbit       = val[31];
      end
      SZ_D: begin
        misalign_o = |addr_lo_i[2:0];
        bmask      = SW'(8'hFF);
        mask       = '1;
        sbit       = val[XLEN-1];
      end
      default: ;
    endcase
  end

  assign strb_o  = bmask << off;
  assign wdata_o = AXI_DW'(wdata_i) << shamt;
  assign ldata_o = (val & mask)
                 | ((sgn_i && sbit) ? ~mask : '0);

endmodule

// File: rtl/lsu_axi_ctrl.sv
// Load/store unit: EXU request -> AXI-Lite master -> WBU result/fault.
// Optional LSU_PERF_CNT_EN adds perf_ld_o/perf_st_o/perf_stall_o.
module lsu_axi_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AXI_AW = 32,
  parameter int AXI_DW = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m_valid_i,
  output logic                m_ready_o,
  input  logic                ren_i,
  input  logic                wen_i,
  input  logic                is_load_signed_i,
  input  logic [1:0]          size_i,
  input  logic [XLEN-1:0]     addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [XLEN-1:0]     rdata_o,
  output logic                err_o,
  output logic [1:0]          err_cause_o,
  output logic                mst_ar_valid_o,
  output logic [AXI_AW-1:0]   ar_addr_o,
  input  logic                ar_ready_i,
  input  logic                mst_r_valid_i,
  input  logic [AXI_DW-1:0]   r_data_i,
  input  axi_resp_t           r_resp_i,
  output logic                r_ready_o,
  output logic                mst_aw_valid_o,
  output logic [AXI_AW-1:0]   aw_addr_o,
  input  logic                aw_ready_i,
  output logic                mst_w_valid_o,
  output logic [AXI_DW-1:0]   w_data_o,
  output logic [AXI_DW/8-1:0] w_strb_o,
  input  logic                w_ready_i,
  input  logic                mst_b_valid_i,
  input  axi_resp_t           b_resp_i,
  output logic                b_ready_o
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [63:0]         perf_ld_o,
  output logic [63:0]         perf_st_o,
  output logic [63:0]         perf_stall_o
`endif
);

  localparam int OW = off_w(AXI_DW);
  localparam int LW = (OW > 3) ? OW : 3;

  lsu_state_e      state_q, state_d;
  lsu_size_e       size_q, size_d, a_size;
  lsu_cause_e      cause_q, cause_d;
  logic [XLEN-1:0] addr_q, addr_d, a_addr;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            sgn_q, sgn_d;
  logic            awd_q, awd_d;
  logic            wd_q, wd_d;
  logic            idle;
  logic            misalign;
  logic            bad_sz;
  logic [XLEN-1:0] ldata;
  logic [XLEN-1:0] line_addr;

  // Misalign is judged on live inputs at accept, data paths on latched.
  assign idle   = (state_q == S_IDLE);
  assign a_size = idle ? lsu_size_e'(size_i) : size_q;
  assign a_addr = idle ? addr_i : addr_q;
  assign bad_sz = (XLEN == 32) && (size_i == 2'd3);

  lsu_align #(
    .XLEN   (XLEN),
    .AXI_DW (AXI_DW)
  ) u_align (
    .size_i     (a_size),
    .addr_lo_i  (a_addr[LW-1:0]),
    .sgn_i      (sgn_q),
    .wdata_i    (wdata_q),
    .rdata_i    (r_data_i),
    .misalign_o (misalign),
    .strb_o     (w_strb_o),
    .wdata_o    (w_data_o),
    .ldata_o    (ldata)
  );

  assign line_addr = {addr_q[XLEN-1:OW], OW'(0)};
  assign ar_addr_o = AXI_AW'(line_addr);
  assign aw_addr_o = AXI_AW'(line_addr);

  assign rdata_o     = res_q;
  assign err_o       = (cause_q != C_NONE);
  assign err_cause_o = cause_q;

  always_comb begin
    state_d        = state_q;
    size_d         = size_q;
    cause_d        = cause_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    res_d          = res_q;
    sgn_d          = sgn_q;
    awd_d          = awd_q;
    wd_d           = wd_q;
    m_ready_o      = 1'b0;
    mst_ar_valid_o = 1'b0;
    r_ready_o      = 1'b0;
    mst_aw_valid_o = 1'b0;
    mst_w_valid_o  = 1'b0;
    b_ready_o      = 1'b0;
    wb_valid_o     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        m_ready_o = 1'b1;
        if (m_valid_i) begin
          addr_d  = addr_i;
          size_d  = lsu_size_e'(size_i);
          sgn_d   = is_load_signed_i;
          wdata_d = wdata_i;
          awd_d   = 1'b0;
          wd_d    = 1'b0;
          res_d   = '0;
          cause_d = C_NONE;
          if ((ren_i && wen_i)
              || ((ren_i || wen_i) && bad_sz)) begin
            cause_d = C_ILLEGAL;
            state_d = S_DONE;
          end else if ((ren_i || wen_i) && misalign) begin
            cause_d = C_MISALIGN;
            state_d = S_DONE;
          end else if (ren_i) begin
            state_d = S_RD_ADDR;
          end else if (wen_i) begin
            state_d = S_WR_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD_ADDR: begin
        mst_ar_valid_o = 1'b1;
        if (ar_ready_i) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        r_ready_o = 1'b1;
        if (mst_r_valid_i) begin
          res_d = ldata;
          if (r_resp_i != AXI_OKAY) cause_d = C_BUS;
          state_d = S_DONE;
        end
      end
      S_WR_REQ: begin
        mst_aw_valid_o = !awd_q;
        mst_w_valid_o  = !wd_q;
        awd_d = awd_q || aw_ready_i;
        wd_d  = wd_q || w_ready_i;
        if (awd_d && wd_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        b_ready_o = 1'b1;
        if (mst_b_valid_i) begin
          if (b_resp_i != AXI_OKAY) cause_d = C_BUS;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      size_q  <= SZ_B;
      cause_q <= C_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      sgn_q   <= 1'b0;
      awd_q   <= 1'b0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      cause_q <= cause_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      sgn_q   <= sgn_d;
      awd_q   <= awd_d;
      wd_q    <= wd_d;
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic [63:0] ld_cnt, st_cnt, stall_cyc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ld_cnt    <= '0;
      st_cnt    <= '0;
      stall_cyc <= '0;
    end else begin
      if (idle && state_d == S_RD_ADDR) ld_cnt <= ld_cnt + 64'd1;
      if (idle && state_d == S_WR_REQ) st_cnt <= st_cnt + 64'd1;
      if (!idle && state_q != S_DONE)
        stall_cyc <= stall_cyc + 64'd1;
    end
  end

  assign perf_ld_o    = ld_cnt;
  assign perf_st_o    = st_cnt;
  assign perf_stall_o = stall_cyc;
`endif

endmodule

// File: tb/tb_lsu_axi_ctrl.sv
// Scoreboard bench for lsu_axi_ctrl: AXI-Lite slave model, WBU monitor,
// directed cases then randomized loads/stores against a reference model.
module tb_lsu_axi_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_valid, m_ready, ren, wen, sgn;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        wb_valid, wb_ready;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  cause;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] ar_addr, r_data, aw_addr, w_data;
  logic [1:0]  r_resp, b_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready;
  logic [3:0]  w_strb;
  logic        b_valid, b_ready;

  always #5 clk = ~clk;

  lsu_axi_ctrl #(.XLEN(32), .AXI_AW(32), .AXI_DW(32)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .m_valid_i(m_valid), .m_ready_o(m_ready),
    .ren_i(ren), .wen_i(wen), .is_load_signed_i(sgn),
    .size_i(size), .addr_i(addr), .wdata_i(wdata),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .rdata_o(rdata), .err_o(err), .err_cause_o(cause),
    .mst_ar_valid_o(ar_valid), .ar_addr_o(ar_addr),
    .ar_ready_i(ar_ready),
    .mst_r_valid_i(r_valid), .r_data_i(r_data),
    .r_resp_i(r_resp), .r_ready_o(r_ready),
    .mst_aw_valid_o(aw_valid), .aw_addr_o(aw_addr),
    .aw_ready_i(aw_ready),
    .mst_w_valid_o(w_valid), .w_data_o(w_data),
    .w_strb_o(w_strb), .w_ready_i(w_ready),
    .mst_b_valid_i(b_valid), .b_resp_i(b_resp),
    .b_ready_o(b_ready)
  );

  typedef struct {
    bit          ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic [1:0]  size;
    logic [1:0]  resp;
  } axi_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  cause;
  } exp_t;

  axi_t txn_q[$];
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   fast = 0, wb_low = 0, r_block = 0;
  int   aw_hold = 0;
  int   ar_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    tests++;
    fails++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [31:0] ld_model(
    input logic [31:0] word, input logic [31:0] a,
    input logic [1:0] sz, input bit s);
    int o = int'(a % 4);
    int n = 1 << sz;
    logic [63:0] msk = (64'd1 << (8 * n)) - 64'd1;
    logic [63:0] v = (64'(word) >> (8 * o)) & msk;
    if (s && v[8*n-1]) v = v | ~msk;
    return v[31:0];
  endfunction

  function automatic logic [3:0] strb_model(
    input logic [31:0] a, input logic [1:0] sz);
    int n = 1 << sz;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] wd_model(
    input logic [31:0] d, input logic [31:0] a);
    return 32'(64'(d) << (8 * (a % 4)));
  endfunction

  // AXI-Lite slave: readies chosen at negedge, handshakes resolved
  // at the following posedge and consumed at the next negedge.
  bit ar_hs, aw_hs, w_hs, r_hs, b_hs;
  bit pend_r, pend_b, aw_got, w_got;
  int r_dly, b_dly;

  initial begin
    ar_ready = 0; aw_ready = 0; w_ready = 0;
    r_valid = 0; b_valid = 0;
    r_data = 0; r_resp = 0; b_resp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
        pend_r = 0; pend_b = 0; aw_got = 0; w_got = 0;
        r_valid = 0; b_valid = 0;
        ar_ready = 0; aw_ready = 0; w_ready = 0;
      end else begin
        if (r_hs || b_hs) begin
          if (txn_q.size() > 0) void'(txn_q.pop_front());
          r_valid = 0;
          b_valid = 0;
        end
        if (ar_hs) begin
          pend_r = 1;
          r_dly = fast ? 0 : $urandom_range(0, 3);
        end
        if (aw_hs) aw_got = 1;
        if (w_hs) w_got = 1;
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; pend_b = 1;
          b_dly = fast ? 0 : $urandom_range(0, 3);
        end
        if (pend_r && !r_block && txn_q.size() > 0) begin
          if (r_dly == 0) begin
            r_valid = 1; pend_r = 0;
            r_data = txn_q[0].rword;
            r_resp = txn_q[0].resp;
          end else r_dly--;
        end
        if (pend_b && txn_q.size() > 0) begin
          if (b_dly == 0) begin
            b_valid = 1; pend_b = 0;
            b_resp = txn_q[0].resp;
          end else b_dly--;
        end
        ar_ready = fast || ($urandom_range(0, 1) == 1);
        w_ready  = fast || ($urandom_range(0, 1) == 1);
        if (aw_hold > 0) begin
          aw_ready = 0;
          if (aw_valid) aw_hold--;
        end else aw_ready = fast || ($urandom_range(0, 1) == 1);
        if (ar_valid) ar_cnt++;
        ar_hs = ar_valid && ar_ready;
        aw_hs = aw_valid && aw_ready;
        w_hs  = w_valid && w_ready;
        r_hs  = r_valid && r_ready;
        b_hs  = b_valid && b_ready;
        if ((ar_hs || aw_hs || w_hs) && txn_q.size() == 0)
          bad("unexpected_axi_request");
        else begin
          if (ar_hs) begin
            if (!txn_q[0].ld) bad("ar_on_store");
            chk("ar_addr", ar_addr, txn_q[0].addr & ~32'h3);
          end
          if (aw_hs) begin
            if (txn_q[0].ld) bad("aw_on_load");
            chk("aw_addr", aw_addr, txn_q[0].addr & ~32'h3);
          end
          if (w_hs) begin
            chk("w_data", w_data,
                wd_model(txn_q[0].wdata, txn_q[0].addr));
            chk("w_strb", 32'(w_strb),
                32'(strb_model(txn_q[0].addr, txn_q[0].size)));
          end
        end
      end
    end
  end

  // WBU monitor / scoreboard.
  initial begin
    exp_t e;
    wb_ready = 0;
    forever begin
      @(negedge clk);
      wb_ready = wb_low ? 1'b0
               : (fast ? 1'b1 : ($urandom_range(0, 3) != 0));
      if (rst_n && wb_valid && wb_ready) begin
        if (exp_q.size() == 0) bad("unexpected_wb_valid");
        else begin
          e = exp_q.pop_front();
          chk("wb_rdata", rdata, e.rdata);
          chk("wb_err", 32'(err), 32'(e.err));
          chk("wb_cause", 32'(cause), 32'(e.cause));
        end
      end
    end
  end

  task automatic do_txn(input bit r, input bit w, input bit s,
                        input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rw,
                        input logic [1:0] rsp, input int lat);
    exp_t e;
    axi_t t;
    int   k;
    bit   mis = (a % (1 << sz)) != 0;
    e.rdata = 0;
    e.cause = 0;
    if (r && w) e.cause = 3;
    else if ((r || w) && mis) e.cause = 1;
    else if (r || w) begin
      t.ld = r; t.addr = a; t.wdata = wd;
      t.rword = rw; t.size = sz; t.resp = rsp;
      txn_q.push_back(t);
      if (rsp != 0) e.cause = 2;
      if (r) e.rdata = ld_model(rw, a, sz, s);
    end
    e.err = (e.cause != 0);
    exp_q.push_back(e);
    @(negedge clk);
    m_valid = 1; ren = r; wen = w; sgn = s;
    size = sz; addr = a; wdata = wd;
    k = 0;
    while (!m_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!m_ready) begin
      bad("accept_timeout");
      m_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    m_valid = 0; ren = $urandom; wen = $urandom; sgn = $urandom;
    size = 2'($urandom); addr = $urandom; wdata = $urandom;
    if (lat > 0) begin
      k = 1;
      while (!wb_valid && k < 200) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("latency", 32'(k), 32'(lat));
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || !m_ready) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) bad("drain_timeout");
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ar"}, 32'(ar_valid), 0);
    chk({nm, "_aw"}, 32'(aw_valid), 0);
    chk({nm, "_w"}, 32'(w_valid), 0);
    chk({nm, "_rrdy"}, 32'(r_ready), 0);
    chk({nm, "_brdy"}, 32'(b_ready), 0);
    chk({nm, "_wbv"}, 32'(wb_valid), 0);
    chk({nm, "_mrdy"}, 32'(m_ready), 1);
  endtask

  initial begin
    int k, pulses, ar0, sel;
    logic [1:0]  rsz;
    logic [31:0] ra;
    m_valid = 0; ren = 0; wen = 0; sgn = 0;
    size = 0; addr = 0; wdata = 0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset_rdata", rdata, 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_cause", 32'(cause), 0);
    rst_n = 1;
    fast = 1;

    do_txn(1, 0, 1, 0, 32'h8000_0003, 0, 32'h80AA_BBCC, 0, 3);
    wait_idle();
    chk("lb_signed_const", rdata, 32'hFFFF_FF80);
    do_txn(1, 0, 0, 1, 32'h8000_0002, 0, 32'hBEEF_1234, 0, 3);
    wait_idle();
    chk("lhu_const", rdata, 32'h0000_BEEF);
    do_txn(0, 1, 0, 2, 32'h8000_0010, 32'h1122_3344, 0, 0, 3);
    wait_idle();

    aw_hold = 3;
    do_txn(0, 1, 0, 1, 32'h8000_0002, 32'h0000_1234, 0, 0, 0);
    chk("sh_c1_aw", 32'(aw_valid), 1);
    chk("sh_c1_w", 32'(w_valid), 1);
    chk("sh_strb", 32'(w_strb), 32'hC);
    chk("sh_wdata", w_data, 32'h1234_0000);
    @(posedge clk);
    #1;
    chk("sh_c2_aw", 32'(aw_valid), 1);
    chk("sh_c2_w", 32'(w_valid), 0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (wb_valid) pulses++;
    end
    chk("sh_wb_pulses", 32'(pulses), 1);
    wait_idle();

    ar0 = ar_cnt;
    do_txn(1, 0, 0, 2, 32'h8000_0006, 0, 0, 0, 1);
    chk("lw_mis_err", 32'(err), 1);
    chk("lw_mis_cause", 32'(cause), 1);
    wait_idle();
    chk("lw_mis_no_ar", 32'(ar_cnt - ar0), 0);

    do_txn(0, 1, 0, 2, 32'h8000_0020, 32'hCAFE_F00D, 0, 2, 3);
    chk("sw_slverr_cause", 32'(cause), 2);
    wait_idle();
    do_txn(1, 1, 0, 2, 32'h8000_0030, 0, 0, 0, 1);
    wait_idle();
    do_txn(0, 0, 0, 2, 32'h8000_0031, 0, 0, 0, 1);
    wait_idle();

    wb_low = 1;
    do_txn(1, 0, 0, 2, 32'h8000_0040, 0, 32'h1234_5678, 0, 3);
    repeat (5) begin
      @(negedge clk);
      chk("stall_wbv", 32'(wb_valid), 1);
      chk("stall_mrdy", 32'(m_ready), 0);
      chk("stall_rdata", rdata, 32'h1234_5678);
      chk("stall_err", 32'(err), 0);
    end
    wb_low = 0;
    wait_idle();

    r_block = 1;
    do_txn(1, 0, 0, 2, 32'h8000_0050, 0, 32'hDEAD_BEEF, 0, 0);
    k = 0;
    while (!r_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reached_rd_data", 32'(r_ready), 1);
    #2;
    rst_n = 0;
    #1;
    chk_quiet("midrst");
    @(negedge clk);
    txn_q.delete();
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1;
    r_block = 0;
    @(negedge clk);
    chk_quiet("post_rst");

    fast = 0;
    repeat (150) begin
      sel = $urandom_range(0, 9);
      rsz = 2'($urandom_range(0, 2));
      ra = $urandom;
      if ($urandom_range(0, 4) != 0) ra = ra & ~((32'd1 << rsz) - 1);
      do_txn(sel <= 3 || sel == 8, (sel >= 4 && sel <= 8),
             $urandom_range(0, 1) == 1, rsz, ra, $urandom,
             $urandom,
             ($urandom_range(0, 5) == 0) ? 2'd2 : 2'd0, 0);
    end
    wait_idle();
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("txn_q_empty", 32'(txn_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

endmodule
